// File: rtl/ff_ctrl_seq.sv
// Control sequencer for the flip-flop bank under test. It synchronises the request
// levels and turns each rising edge into one clean clear, preset or enable pulse.
module ff_ctrl_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int LEN_W       = 4,
  parameter int GAP         = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clr_req,
  input  logic             pre_req,
  input  logic             en_req,
  input  logic [LEN_W-1:0] pulse_len,
  input  logic             d_in,
  output logic             d_out,
  output logic             clr_out,
  output logic             pre_out,
  output logic             en_out,
  output logic             busy,
  output logic             done,
  output logic             err_overlap
);

  localparam int GAP_W = $clog2(GAP + 1);
  localparam int CNT_W = (LEN_W > GAP_W) ? LEN_W : GAP_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_HOLD,
    S_PULSE_CLR,
    S_PULSE_PRE,
    S_PULSE_EN,
    S_GAP
  } state_t;

  // Request vectors are indexed 0 = clr, 1 = pre, 2 = en, which is also priority order.
  logic [2:0]                  w_req;
  logic [2:0][SYNC_STAGES-1:0] r_sync;
  logic [2:0]                  r_prev;
  logic [2:0]                  w_edge;
  logic [2:0]                  w_cand;
  logic [2:0]                  w_sel;
  logic [2:0]                  r_pend;
  logic [SYNC_STAGES-1:0]      r_rst_sr;
  logic [CNT_W-1:0]            r_cnt;
  logic [CNT_W-1:0]            w_len_m1;
  state_t                      r_state;
  logic                        r_clr_out;
  logic                        r_pre_out;
  logic                        r_en_out;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_err;
  logic                        r_d;

  assign w_req = {en_req, pre_req, clr_req};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_sync   <= '0;
      r_prev   <= '0;
      r_rst_sr <= '0;
      r_d      <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_req[i]};
        r_prev[i] <= r_sync[i][SYNC_STAGES-1];
      end
      r_rst_sr <= {r_rst_sr[SYNC_STAGES-2:0], 1'b1};
      r_d      <= d_in;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_edge[i] = r_sync[i][SYNC_STAGES-1] & ~r_prev[i];
    end
  end

  assign w_cand = r_pend | w_edge;

  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    w_sel = 3'b000;
    if (w_cand[0])      w_sel = 3'b001;
    else if (w_cand[1]) w_sel = 3'b010;
    else if (w_cand[2]) w_sel = 3'b100;
  end

  assign w_len_m1 = (pulse_len == '0) ? '0 : CNT_W'(pulse_len - 1'b1);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state   <= S_RST_HOLD;
      r_cnt     <= '0;
      r_pend    <= '0;
      r_clr_out <= 1'b1;
      r_pre_out <= 1'b0;
      r_en_out  <= 1'b0;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= r_err | (|(w_edge & r_pend));
      // Only an IDLE visit consumes a request; any other state just queues new edges.
      if (r_state == S_IDLE) r_pend <= w_cand & ~w_sel;
      else                   r_pend <= r_pend | w_edge;

      case (r_state)
        S_RST_HOLD: begin
          if (r_rst_sr[SYNC_STAGES-1]) begin
            r_state   <= S_IDLE;
            r_clr_out <= 1'b0;
            r_busy    <= 1'b0;
          end
        end
        S_IDLE: begin
          if (w_sel != 3'b000) begin
            r_busy    <= 1'b1;
            r_cnt     <= w_len_m1;
            r_clr_out <= w_sel[0];
            r_pre_out <= w_sel[1];
            r_en_out  <= w_sel[2];
            r_state   <= w_sel[0] ? S_PULSE_CLR : (w_sel[1] ? S_PULSE_PRE : S_PULSE_EN);
          end
        end
        S_PULSE_CLR, S_PULSE_PRE, S_PULSE_EN: begin
          if (r_cnt == '0) begin
            r_state   <= S_GAP;
            r_cnt     <= CNT_W'(GAP - 1);
            r_clr_out <= 1'b0;
            r_pre_out <= 1'b0;
            r_en_out  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign d_out       = r_d;
  assign clr_out     = r_clr_out;
  assign pre_out     = r_pre_out;
  assign en_out      = r_en_out;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err_overlap = r_err;

endmodule
